quad_debounce: RTL and testbench
================================

Name: quad_debounce

Overview:
Conditions raw rotary-encoder pins (and optional push-button) before they reach the quadrature encoder stage. Each channel passes through a metastability synchronizer, then a prescaled stability filter; a channel's clean level changes only after the new level has been held for a programmable number of consecutive sample ticks. Outputs feed the encoder's a/b inputs directly; rise/fall strobes are provided for button-style consumers.

Parameters:
CHANNELS, 2, number of independent input channels (>=1)
SYNC_STAGES, 2, synchronizer flop depth per channel (>=2)
PRESCALE, 16, clocks per sample tick (>=1; 1 = sample every clock)
STABLE_COUNT, 8, consecutive differing samples required to accept a new level (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_raw  input  CHANNELS  raw asynchronous pin levels
out_clean  output  CHANNELS  debounced levels (registered)
rose  output  CHANNELS  1-cycle pulse when out_clean[i] goes 0->1
fell  output  CHANNELS  1-cycle pulse when out_clean[i] goes 1->0
tick  output  1  1-cycle sample strobe (for bench observability)

Behaviour:
- Reset (async assert, sync release by system): synchronizer flops, prescaler, all per-channel counters, out_clean, rose, fell, tick all 0.
- Synchronizer: SYNC_STAGES-deep shift per channel, no filtering; sync[i] = last stage.
- Prescaler: counter 0..PRESCALE-1, increments every clock, wraps to 0; tick=1 in the cycle counter==PRESCALE-1. PRESCALE=1: tick constantly 1. Counter width clog2(PRESCALE), min 1 bit.
- Per channel, counter cnt width clog2(STABLE_COUNT+1); updates only on tick cycles, holds otherwise:
  - sync[i]==out_clean[i]: cnt<=0 (any agreeing sample discards progress; single-sample glitch never propagates).
  - sync[i]!=out_clean[i] and cnt==STABLE_COUNT-1: out_clean[i]<=sync[i], cnt<=0, rose[i] or fell[i] =1 for exactly that next cycle.
  - else: cnt<=cnt+1.
- rose/fell registered, asserted in the same cycle out_clean changes, 0 all other cycles; rose[i] and fell[i] never both 1.
- Channels fully independent; simultaneous changes on several channels each handled with no interaction, may update in same cycle.
- Latency (PRESCALE=1): new in_raw level, held steady, appears on out_clean at rising edge SYNC_STAGES+STABLE_COUNT, counting the first edge sampling the new level as edge 1. General PRESCALE: between SYNC_STAGES+(STABLE_COUNT-1)*PRESCALE+1 and SYNC_STAGES+STABLE_COUNT*PRESCALE edges, depending on prescaler phase.
- Input bouncing back before acceptance: cnt returns to 0 on first agreeing tick, out_clean unchanged.
- Reset mid-count: all state cleared immediately; after release out_clean=0 even if in_raw=1, then normal filtering (in_raw held 1 gives rose after normal latency).
- No combinational path from in_raw to any output.

Test Plan:
- PRESCALE=1, STABLE_COUNT=8, SYNC_STAGES=2: reset, in_raw 0->1 held -> out_clean[0] rises on edge 10, rose[0] high for exactly that one cycle, fell 0.
- Same config, in_raw[0] high for 7 clocks then low -> out_clean stays 0, no rose/fell pulse ever.
- Defaults (PRESCALE=16): tick every 16 clocks; in_raw[1] 1->0 after out_clean[1]=1 -> out_clean[1] falls within 2+7*16+1=115 to 2+8*16=130 edges, fell[1] single pulse.
- Defaults, alternate in_raw[0] every 20 clocks for 500 clocks (bounce faster than 8 ticks) -> out_clean[0] constant, then hold 1 -> accepted once, exactly one rose.
- Both channels toggled simultaneously, held -> both out_clean bits update in the same cycle, each with own rose pulse.
- Assert reset with cnt at 5 and in_raw=1 -> out_clean, cnt, tick 0 immediately (asynchronously, before next edge); after release rose appears after full latency, not early.

Source files
------------

// File: rtl/quad_debounce.sv
// -----------------------------------------------------------------------------
// quad_debounce
//
// Conditions raw rotary-encoder / push-button pins before the quadrature
// encoder. Each channel goes through a metastability synchronizer and then a
// prescaled stability filter. A channel's clean level only changes after the
// opposite level has been seen on STABLE_COUNT consecutive sample ticks.
//
// Parameters:
//   CHANNELS     number of independent input channels (>=1)
//   SYNC_STAGES  synchronizer depth per channel (>=2)
//   PRESCALE     clocks per sample tick (>=1, 1 = sample every clock)
//   STABLE_COUNT consecutive differing samples needed to accept a level (>=1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_raw     raw asynchronous pin levels
//   out_clean  debounced levels (registered)
//   rose       1-cycle pulse when out_clean[i] goes 0->1 (registered)
//   fell       1-cycle pulse when out_clean[i] goes 1->0 (registered)
//   tick       1-cycle sample strobe (registered)
// -----------------------------------------------------------------------------
module quad_debounce #(
    parameter int CHANNELS     = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int PRESCALE     = 16,
    parameter int STABLE_COUNT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] out_clean,
    output logic [CHANNELS-1:0] rose,
    output logic [CHANNELS-1:0] fell,
    output logic                tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = (STABLE_COUNT > 0) ? $clog2(STABLE_COUNT + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

    // Synchronizer chains: bit 0 is the first stage, bit SYNC_STAGES-1 the last.
    logic [SYNC_STAGES-1:0] sync_r [CHANNELS];
    logic [CHANNELS-1:0]    sync_s;

    // Prescaler state. tick_r is the registered image of "counter is at its
    // last value", so every consumer sees the strobe without a comb path.
    logic [PW-1:0]          pre_r;
    logic [PW-1:0]          pre_next_s;
    logic                   tick_r;

    // Per-channel filter state and its next-state values.
    logic [CW-1:0]          cnt_r      [CHANNELS];
    logic [CW-1:0]          cnt_next_s [CHANNELS];
    logic [CHANNELS-1:0]    clean_r;
    logic [CHANNELS-1:0]    clean_next_s;
    logic [CHANNELS-1:0]    rose_r;
    logic [CHANNELS-1:0]    rose_next_s;
    logic [CHANNELS-1:0]    fell_r;
    logic [CHANNELS-1:0]    fell_next_s;

    // Shift each raw pin through its synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                sync_r[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                sync_r[ch] <= {sync_r[ch][SYNC_STAGES-2:0], in_raw[ch]};
            end
        end
    end

    // Pick the last synchronizer stage of every channel.
    always_comb begin
        sync_s = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sync_s[ch] = sync_r[ch][SYNC_STAGES-1];
        end
    end

    // Prescaler next value: free-running 0..PRESCALE-1 with wrap.
    always_comb begin
        pre_next_s = pre_r;
        if (pre_r == PRE_LAST) begin
            pre_next_s = '0;
        end else begin
            pre_next_s = pre_r + PW'(1);
        end
    end

    // Prescaler counter and registered sample strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            pre_r  <= pre_next_s;
            tick_r <= (pre_next_s == PRE_LAST);
        end
    end

    // Stability filter next state. Any agreeing sample discards progress, so a
    // bounce that returns before acceptance leaves the clean level untouched.
    always_comb begin
        clean_next_s = clean_r;
        rose_next_s  = '0;
        fell_next_s  = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_next_s[ch] = cnt_r[ch];
            if (tick_r) begin
                if (sync_s[ch] == clean_r[ch]) begin
                    cnt_next_s[ch] = '0;
                end else if (cnt_r[ch] == CNT_LAST) begin
                    cnt_next_s[ch]   = '0;
                    clean_next_s[ch] = sync_s[ch];
                    rose_next_s[ch]  = sync_s[ch];
                    fell_next_s[ch]  = ~sync_s[ch];
                end else begin
                    cnt_next_s[ch] = cnt_r[ch] + CW'(1);
                end
            end else begin
                cnt_next_s[ch] = cnt_r[ch];
            end
        end
    end

    // Filter registers: counters, clean levels and edge strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_r[ch] <= '0;
            end
            clean_r <= '0;
            rose_r  <= '0;
            fell_r  <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_r[ch] <= cnt_next_s[ch];
            end
            clean_r <= clean_next_s;
            rose_r  <= rose_next_s;
            fell_r  <= fell_next_s;
        end
    end

    assign out_clean = clean_r;
    assign rose      = rose_r;
    assign fell      = fell_r;
    assign tick      = tick_r;

endmodule

// File: tb/tb_quad_debounce.sv
// -----------------------------------------------------------------------------
// tb_quad_debounce
//
// Two instances share stimulus: u_fast (PRESCALE=1) and u_slow (PRESCALE=16).
// A reference model pushes the expected outputs of every cycle into a per-
// instance queue; a monitor on the falling edge pops and compares. The model
// keeps a sliding window of the last STABLE_COUNT tick samples per channel and
// flips the clean level when the whole window disagrees with it.
// -----------------------------------------------------------------------------
module tb_quad_debounce;

    localparam int SYNC = 2;
    localparam int K    = 8;

    typedef struct packed {
        logic [1:0] clean;
        logic [1:0] rose;
        logic [1:0] fell;
        logic       tick;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] in_raw = 2'b00;

    logic [1:0] f_clean, f_rose, f_fell;
    logic       f_tick;
    logic [1:0] s_clean, s_rose, s_fell;
    logic       s_tick;

    int checks = 0;
    int errors = 0;

    exp_t       sb_q    [2][$];
    logic [1:0] hist    [2][$];
    bit         win     [2][2][$];
    int         ncyc    [2];
    logic [1:0] clean_m [2];
    int         rose_cnt[2][2];
    int         fell_cnt[2][2];

    always #5 clk = ~clk;

    quad_debounce #(.CHANNELS(2), .SYNC_STAGES(SYNC), .PRESCALE(1), .STABLE_COUNT(K)) u_fast (
        .clk(clk), .reset(reset), .in_raw(in_raw),
        .out_clean(f_clean), .rose(f_rose), .fell(f_fell), .tick(f_tick)
    );

    quad_debounce #(.CHANNELS(2), .SYNC_STAGES(SYNC), .PRESCALE(16), .STABLE_COUNT(K)) u_slow (
        .clk(clk), .reset(reset), .in_raw(in_raw),
        .out_clean(s_clean), .rose(s_rose), .fell(s_fell), .tick(s_tick)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle c counted from reset release; the strobe register starts at 0.
    function automatic bit exp_tick(input int c, input int p);
        if (p == 1) return (c >= 1);
        return ((c % p) == (p - 1));
    endfunction

    function automatic exp_t get_out(input int d);
        exp_t o;
        if (d == 0) o = {f_clean, f_rose, f_fell, f_tick};
        else        o = {s_clean, s_rose, s_fell, s_tick};
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ncyc[d]    = 0;
            clean_m[d] = 2'b00;
            hist[d].delete();
            for (int s = 0; s < SYNC; s++) hist[d].push_back(2'b00);
            sb_q[d].delete();
            for (int ch = 0; ch < 2; ch++) win[d][ch].delete();
        end
    endtask

    task automatic model_step(input int d, input logic [1:0] raw);
        int         p;
        logic [1:0] sy;
        logic [1:0] r;
        logic [1:0] f;
        bit         all_diff;
        exp_t       e;
        p  = (d == 0) ? 1 : 16;
        r  = 2'b00;
        f  = 2'b00;
        sy = hist[d].pop_front();
        hist[d].push_back(raw);
        if (exp_tick(ncyc[d], p)) begin
            for (int ch = 0; ch < 2; ch++) begin
                win[d][ch].push_back(sy[ch]);
                if (win[d][ch].size() > K) void'(win[d][ch].pop_front());
                if (win[d][ch].size() == K) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < K; k++)
                        if (win[d][ch][k] == clean_m[d][ch]) all_diff = 1'b0;
                    if (all_diff) begin
                        clean_m[d][ch] = sy[ch];
                        if (sy[ch]) r[ch] = 1'b1;
                        else        f[ch] = 1'b1;
                        win[d][ch].delete();
                    end
                end
            end
        end
        ncyc[d]++;
        e.clean = clean_m[d];
        e.rose  = r;
        e.fell  = f;
        e.tick  = exp_tick(ncyc[d], p);
        sb_q[d].push_back(e);
    endtask

    // Reference model: one step per rising edge, cleared by reset.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_reset();
            end else begin
                model_step(0, in_raw);
                model_step(1, in_raw);
            end
        end
    end

    // Monitor: compare DUT outputs with the scoreboard on every falling edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                a = get_out(d);
                if (reset) begin
                    chk($sformatf("reset_outputs_inst%0d", d), 32'(a), 32'd0);
                end else if (sb_q[d].size() == 0) begin
                    chk($sformatf("sb_underflow_inst%0d", d), 32'd0, 32'd1);
                end else begin
                    e = sb_q[d].pop_front();
                    chk($sformatf("sb_inst%0d", d), 32'(a), 32'(e));
                    for (int ch = 0; ch < 2; ch++) begin
                        if (a.rose[ch] === 1'b1) rose_cnt[d][ch]++;
                        if (a.fell[ch] === 1'b1) fell_cnt[d][ch]++;
                    end
                end
            end
        end
    end

    task automatic set_raw(input logic [1:0] v);
        @(negedge clk);
        #1;
        in_raw = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  r0;
        int  f0;
        bit  hit;
        logic [1:0] v;
        int  hold;

        // Reset held for a few cycles; the monitor checks zero outputs.
        repeat (3) @(posedge clk);

        // Fast instance latency: new level appears on edge SYNC+K = 10.
        @(negedge clk);
        #1;
        reset  = 1'b0;
        in_raw = 2'b01;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
            if (e == 9)  chk("fast_clean_before_edge10", 32'(f_clean[0]), 32'd0);
            if (e == 10) begin
                chk("fast_clean_at_edge10", 32'(f_clean[0]), 32'd1);
                chk("fast_rose_at_edge10", 32'(f_rose[0]), 32'd1);
                chk("fast_fell_at_edge10", 32'(f_fell[0]), 32'd0);
            end
            if (e == 11) chk("fast_rose_one_cycle", 32'(f_rose[0]), 32'd0);
        end
        wait_cyc(150);
        set_raw(2'b00);
        wait_cyc(150);

        // Seven-clock glitch on the fast instance must never be accepted.
        r0 = rose_cnt[0][0];
        f0 = fell_cnt[0][0];
        set_raw(2'b01);
        wait_cyc(6);
        set_raw(2'b00);
        wait_cyc(30);
        chk("glitch_no_rose", 32'(rose_cnt[0][0]), 32'(r0));
        chk("glitch_no_fell", 32'(fell_cnt[0][0]), 32'(f0));
        chk("glitch_clean_low", 32'(f_clean[0]), 32'd0);

        // Slow instance falling latency on channel 1.
        set_raw(2'b10);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (s_clean[1] === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("slow_ch1_rise_timeout", 32'(hit), 32'd1);
        f0 = fell_cnt[1][1];
        set_raw(2'b00);
        lat = 0;
        while (s_clean[1] !== 1'b0 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("slow_fall_latency_min", 32'(lat >= 115), 32'd1);
        chk("slow_fall_latency_max", 32'(lat <= 130), 32'd1);
        wait_cyc(5);
        chk("slow_fell_single_pulse", 32'(fell_cnt[1][1] - f0), 32'd1);

        // Bounce faster than the filter window, then hold high.
        r0 = rose_cnt[1][0];
        f0 = fell_cnt[1][0];
        for (int i = 0; i < 25; i++) begin
            set_raw((i % 2 == 0) ? 2'b01 : 2'b00);
            repeat (19) @(posedge clk);
        end
        chk("bounce_no_rose", 32'(rose_cnt[1][0]), 32'(r0));
        chk("bounce_no_fell", 32'(fell_cnt[1][0]), 32'(f0));
        chk("bounce_clean_low", 32'(s_clean[0]), 32'd0);
        wait_cyc(200);
        chk("bounce_hold_one_rose", 32'(rose_cnt[1][0] - r0), 32'd1);
        chk("bounce_hold_clean_high", 32'(s_clean[0]), 32'd1);

        // Both channels change together and update in the same cycle.
        set_raw(2'b00);
        wait_cyc(200);
        set_raw(2'b11);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (s_clean !== 2'b00) begin
                chk("simul_clean_both", 32'(s_clean), 32'd3);
                chk("simul_rose_both", 32'(s_rose), 32'd3);
                hit = 1'b1;
                break;
            end
        end
        chk("simul_timeout", 32'(hit), 32'd1);

        // Reset asserted mid-count clears everything immediately.
        set_raw(2'b00);
        wait_cyc(200);
        set_raw(2'b01);
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_fast", 32'({f_clean, f_rose, f_fell, f_tick}), 32'd0);
        chk("async_reset_slow", 32'({s_clean, s_rose, s_fell, s_tick}), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        lat = 0;
        while (f_rose[0] !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("post_reset_full_latency", 32'(lat), 32'd10);

        // Random hold segments against the reference model.
        for (int s = 0; s < 30; s++) begin
            v    = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 200);
            set_raw(v);
            repeat (hold) @(posedge clk);
        end

        wait_cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
